// File: rtl/ms_timer_pkg.sv
// Shared types and constants for the millisecond timer family
// (elapsed counter and countdown).
package ms_timer_pkg;

  localparam int unsigned CLKS_PER_MS_DEFAULT = 5000;
  localparam int unsigned CNT_W_DEFAULT       = 16;

  typedef logic [CNT_W_DEFAULT-1:0] ms_cnt_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ms_state_e;

endpackage

// File: rtl/ms_countdown_if.sv
// Host-side control/status bundle of the millisecond countdown timer.
interface ms_countdown_if #(
    parameter int unsigned CNT_W = 16
);

    logic             start;
    logic [CNT_W-1:0] load_ms;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] remaining_ms;
    logic             ms_tick;
    logic             expired;

    modport master (
        output start,
        output load_ms,
        output abort,
        input  busy,
        input  remaining_ms,
        input  ms_tick,
        input  expired
    );

    modport slave (
        input  start,
        input  load_ms,
        input  abort,
        output busy,
        output remaining_ms,
        output ms_tick,
        output expired
    );

endinterface

// File: rtl/ms_prescaler.sv
// Divides clk into one tick per millisecond; tick is high in the last
// cycle of each millisecond while enabled.
module ms_prescaler
    import ms_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     PS_W = $clog2(CLKS_PER_MS);
    localparam logic [PS_W-1:0] LAST = PS_W'(CLKS_PER_MS - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/ms_countdown.sv
// Programmable millisecond countdown: load a duration, count it down once
// per millisecond tick, pulse expired for one cycle on completion.
module ms_countdown
    import ms_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    ms_countdown_if.slave bus
);

    ms_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             start_acc;
    logic             ps_clear;
    logic             tick;

    // abort outranks start, even in IDLE where abort itself does nothing
    assign start_acc = bus.start && !bus.abort;
    assign ps_clear  = start_acc || (state_q != StRun);

    ms_prescaler #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (ps_clear),
        .enable(state_q == StRun),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (bus.abort) begin
            if (state_q != StIdle) begin
                state_d = StIdle;
            end
        end else if (bus.start) begin
            rem_d   = bus.load_ms;
            state_d = (bus.load_ms != '0) ? StRun : StDone;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (tick && (rem_q != '0)) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy         = (state_q == StRun);
    assign bus.expired      = (state_q == StDone);
    assign bus.remaining_ms = rem_q;
    assign bus.ms_tick      = tick;

endmodule

// File: doc/ms_countdown.md
Name: ms_countdown

Overview:
Programmable millisecond countdown timer; the down-counting counterpart to the team's elapsed-millisecond counter.
- The host loads a duration in ms and pulses start.
- The block prescales clk into 1 ms ticks, decrements the remaining count once per tick, and emits a one-cycle expired pulse when the count reaches zero.
- Used for timeouts, debounce windows and delay generation alongside the elapsed-ms measurement logic.

Parameters:
CLKS_PER_MS, 5000, clk cycles per millisecond; legal range 2 or more.
CNT_W, 16, width of load/remaining millisecond count.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  single-cycle request: load load_ms and begin counting.
load_ms  input  CNT_W  duration in ms; sampled only on an edge where start is accepted.
abort  input  1  cancel the active countdown.
busy  output  1  high in RUN state.
remaining_ms  output  CNT_W  ms still to elapse.
ms_tick  output  1  high in the cycle before each decrement edge.
expired  output  1  one-cycle pulse when the countdown completes.

Behaviour:
- Reset: asynchronous, active-high. State = IDLE; prescaler = 0; remaining_ms = 0; busy = 0; expired = 0; ms_tick = 0. Reset mid-run discards the countdown and no expired pulse is produced.
- FSM states: IDLE, RUN, DONE.
- Priority on any edge: rst, then abort, then start, then normal counting.
- IDLE, start=1, load_ms != 0: at edge N go to RUN; remaining_ms = load_ms; prescaler = 0.
- IDLE, start=1, load_ms == 0: go to DONE directly; expired is high in the cycle after edge N.
- RUN prescaler:
  - Counts 0 to CLKS_PER_MS-1 and wraps to 0.
  - ms_tick = (state == RUN) && (prescaler == CLKS_PER_MS-1), combinational.
  - On a wrap edge, remaining_ms decrements by 1.
  - Decrements occur at edges N + k*CLKS_PER_MS.
- Completion:
  - At the wrap edge where remaining_ms == 1, remaining_ms goes to 0 and the state goes to DONE.
  - expired is high for exactly the one cycle spent in DONE, i.e. the cycle after edge N + load_ms*CLKS_PER_MS.
  - The next edge goes to IDLE.
- Retrigger: start while in RUN or DONE restarts the count from the new load_ms with prescaler = 0.
  - No expired pulse is generated for the interrupted count.
  - If start coincides with the DONE cycle, the expired pulse for the completed count still appears in that cycle.
- abort:
  - In RUN or DONE: go to IDLE at the next edge; remaining_ms holds its value; no later expired pulse.
  - In IDLE: no effect.
  - abort together with start: abort wins and start is ignored.
- busy = (state == RUN); registered state decode, no glitch paths to inputs.
- Arithmetic: remaining_ms never underflows, because the decrement is gated by state == RUN and remaining_ms != 0.
- Prescaler width is $clog2(CLKS_PER_MS); the comparison uses CLKS_PER_MS-1 at full width.
- load_ms is not sampled outside an accepted start; changes while in RUN are ignored.

Decomposition:
- Shared package ms_timer_pkg:
  - Typedef for the state enum (IDLE, RUN, DONE).
  - Default constant CLKS_PER_MS_DEFAULT = 5000.
  - Typedef for the CNT_W count, so the elapsed counter and countdown share widths.
- Sub-module ms_prescaler:
  - Inputs: clk, rst, clear, enable. Output: tick.
  - Parameter CLKS_PER_MS.
  - Reusable by the existing elapsed-ms counter.
- The FSM and remaining_ms register live in ms_countdown.

Test Plan (CLKS_PER_MS=4 unless stated):
- Reset: rst=1 mid-sim with a prior count active -> immediately busy=0, remaining_ms=0, expired=0, ms_tick=0; no expired pulse after release.
- Basic: start with load_ms=3 at edge N -> busy from N; remaining_ms 3→2→1→0 at N+4, N+8, N+12; expired high only in the cycle after N+12; busy low from N+12.
- Zero load: start with load_ms=0 -> no busy; expired high one cycle after the start edge; remaining_ms=0.
- Abort: load_ms=5, abort at edge N+6 -> IDLE, remaining_ms holds 4, no expired pulse for the next 30 cycles.
- Abort+start same cycle during RUN -> IDLE; the start is ignored.
- Retrigger: load_ms=2, start with load_ms=1 at N+5 -> expired only in the cycle after N+9; no pulse at N+8.
- Default CLKS_PER_MS=5000, load_ms=2 -> expired exactly 10000 edges after start; ms_tick pulses once per 5000 cycles while busy.
